muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer that adds RV32M operations beside the single-cycle integer ALU. It accepts one operation from decode, runs a shift-add or restoring-divide loop over XLEN cycles, and holds the core via a stall signal until the result is ready. It sits in the execute stage, and its result is muxed onto the writeback path alongside the ALU output.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets on the next rising clk edge)
start  input  1  decode asserts for an M-extension instruction; held high until done
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  XLEN  operand a (dividend / multiplicand)
rs2  input  XLEN  operand b (divisor / multiplier)
flush  input  1  abort the current operation (trap/redirect)
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
result  output  XLEN  final result, held until the next accept
stall  output  1  freeze the PC/regfile write: start & ~done

Behaviour:
- States: IDLE, PREP, CALC, FIX, DONE.
- Reset (rst==0 at a clk edge), in any state: next state IDLE; busy=0, done=0, result=0, iteration counter=0. Reset has priority over flush, and flush has priority over start.
- Accept: state IDLE, start=1, flush=0 at edge T. Latch op, rs1, rs2. Cycle T+1 is PREP.
- PREP:
  - Compute operand signs: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed, rs2 unsigned.
  - Take absolute values into the internal operand regs. Clear the 2*XLEN accumulator/remainder. Counter = XLEN-1.
- PREP special cases (divide ops only), with fast path PREP -> DONE so done is asserted in cycle T+2:
  - rs2==0: DIV/DIVU give all ones; REM/REMU give rs1.
  - DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- CALC runs cycles T+2 .. T+XLEN+1, one iteration per cycle, counter decrementing:
  - Multiply: if multiplier LSB is 1, add the multiplicand into the upper half; shift right 1.
  - Divide: shift remainder:quotient left 1; trial subtract the divisor; if non-negative, keep the result and set quotient LSB=1.
  - CALC exits to FIX when the counter reaches 0 during that cycle.
- FIX (cycle T+XLEN+2) applies sign correction and selects the result:
  - Product: negate if the operand signs differ (signed forms only).
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Selection: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
- DONE (cycle T+XLEN+3; default 35 cycles after T): done=1, busy=0, result valid. Next state is IDLE unconditionally; start is not accepted in DONE.
- busy=1 in PREP, CALC and FIX; 0 otherwise.
- result register updates only on entry to DONE. It is held stable through IDLE until the next DONE.
- Operands are sampled only at accept; input changes during busy are ignored.
- flush=1 in any non-IDLE state: next state IDLE, no done pulse, result unchanged. flush in IDLE blocks accept.
- start held high across DONE -> IDLE: the core advances the PC on done, so IDLE sees the next instruction's start. A start still high in IDLE (a back-to-back M op) is a new accept.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD: accept at T -> done only at T+35; result 0xFFFFFFEB; busy high T+1..T+34; stall low at T+35.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 100/7 -> 14 and REMU -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; each done at T+35.
- Fast paths, each with done at T+2:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- rst=0 at T+10 of a DIV -> next cycle busy=0, done=0, result=0; no done pulse ever; a new MUL 3x4 accepted afterwards gives result 12 at accept+35.
- Flush at T+5: no done, result keeps the prior value. Back-to-back: start held high after done with new operands 6x7 -> second accept at the IDLE cycle, result 42.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Decode/execute handshake for the iterative M-extension unit; no latency of its own.
// Backpressure is the stall line: decode holds start and operands until done.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, done, result, stall
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M shift-add multiply / restoring divide; done XLEN+3 cycles after accept (2 for divide special cases).
// Backpressure: stall = start & ~done freezes the core; flush aborts without a done pulse.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic              neg_a_q;
    logic              neg_res_q;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              is_div;
    logic              is_rem;
    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_val;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;
    logic              result_ld;
    logic [XLEN-1:0]   result_nxt;

    assign accept   = (state == S_IDLE) && bus.start && !bus.flush;
    assign is_div   = op_q[2];
    assign is_rem   = op_q[1];

    // MULH, MULHSU, DIV and REM treat rs1 as signed; MULHSU leaves rs2 unsigned.
    assign signed_a = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    assign signed_b = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    assign neg_a    = signed_a && rs1_q[XLEN-1];
    assign neg_b    = signed_b && rs2_q[XLEN-1];
    assign abs_a    = neg_a ? -rs1_q : rs1_q;
    assign abs_b    = neg_b ? -rs2_q : rs2_q;

    assign div_zero = is_div && (rs2_q == '0);
    assign div_ovf  = is_div && !op_q[0] && (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_q == '1);
    assign fast     = div_zero || div_ovf;
    assign fast_val = div_zero ? (is_rem ? rs1_q : '1) : (is_rem ? '0 : rs1_q);

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[XLEN-1:1]};

    // Divide: acc holds remainder:quotient; the dividend enters through the low half.
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign rem_ge   = rem_sh >= {1'b0, opnd};
    assign rem_new  = rem_ge ? XLEN'(rem_sh - {1'b0, opnd}) : rem_sh[XLEN-1:0];
    assign div_step = {rem_new, acc[XLEN-2:0], rem_ge};

    assign prod     = neg_res_q ? -acc : acc;
    assign quo      = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem      = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = prod[2*XLEN-1:XLEN];
        if (is_div) begin
            fix_val = is_rem ? rem : quo;
        end else if (op_q == 3'b000) begin
            fix_val = prod[XLEN-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_PREP;
            S_PREP:  state_nxt = fast ? S_DONE : S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // Only PREP and FIX can enter DONE, so the result source follows the current state.
    assign result_ld  = (state_nxt == S_DONE);
    assign result_nxt = (state == S_PREP) ? fast_val : fix_val;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            neg_a_q   <= 1'b0;
            neg_res_q <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            cnt       <= '0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.op;
                rs1_q <= bus.rs1;
                rs2_q <= bus.rs2;
            end
            case (state)
                S_PREP: begin
                    neg_a_q   <= neg_a;
                    neg_res_q <= neg_a ^ neg_b;
                    opnd      <= is_div ? abs_b : abs_a;
                    acc       <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                    cnt       <= CW'(XLEN - 1);
                end
                S_CALC: begin
                    acc <= is_div ? div_step : mul_step;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
            if (result_ld) begin
                result_q <= result_nxt;
            end
        end
    end

    assign bus.busy   = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.stall  = bus.start && !bus.done;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, multiply/divide results, divide special cases,
// mid-operation reset, flush and back-to-back issue.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    muldiv_seq_if #(.XLEN(32)) bus();

    muldiv_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    // Drives an operation and returns right after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk);
    endtask

    // Waits (bounded) for done; at is the cycle offset from the accept edge, -1 on timeout.
    task automatic wait_done(input logic hold, output int at, output logic [31:0] res,
                             output int bcnt, output logic stl);
        at = -1; res = '0; bcnt = 0; stl = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (bus.done) begin
                at  = k;
                res = bus.result;
                stl = bus.stall;
                break;
            end
            if (bus.busy) bcnt++;
        end
        if (!hold || at < 0) bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.rs1 = '0; bus.rs2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        rst = 1'b1;
    endtask

    task automatic test_mul();
        int at, bcnt; logic [31:0] res; logic stl;
        issue(MUL, 32'd7, 32'hFFFF_FFFD);
        #1;
        bus.op = REMU; bus.rs1 = 32'h1234_5678; bus.rs2 = 32'h0;
        wait_done(1'b0, at, res, bcnt, stl);
        checks++; if (at !== 35) begin errors++; $display("FAIL mul_latency: got %0d want 35", at); end
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", res); end
        checks++; if (bcnt !== 34) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 34", bcnt); end
        checks++; if (stl !== 1'b0) begin errors++; $display("FAIL mul_stall_at_done: got %b want 0", stl); end
    endtask

    task automatic test_mulh();
        int at, bcnt; logic [31:0] res; logic stl;
        issue(MULH, 32'h8000_0000, 32'h8000_0000);
        wait_done(1'b0, at, res, bcnt, stl);
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulh_result: got %h want 40000000", res); end
        issue(MULHU, 32'h8000_0000, 32'h8000_0000);
        wait_done(1'b0, at, res, bcnt, stl);
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulhu_result: got %h want 40000000", res); end
        issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, at, res, bcnt, stl);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_result: got %h want ffffffff", res); end
        checks++; if (at !== 35) begin errors++; $display("FAIL mulhsu_latency: got %0d want 35", at); end
    endtask

    task automatic test_div();
        int at, bcnt; logic [31:0] res; logic stl;
        logic [2:0]  ops [4] = '{DIVU, REMU, DIV, REM};
        logic [31:0] as  [4] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'd2, 32'd2};
        logic [31:0] exp [4] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(1'b0, at, res, bcnt, stl);
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, exp[i]); end
            checks++; if (at !== 35) begin errors++; $display("FAIL div_latency[%0d]: got %0d want 35", i, at); end
        end
    endtask

    task automatic test_fast_path();
        int at, bcnt; logic [31:0] res; logic stl;
        logic [2:0]  ops [4] = '{DIVU, REMU, DIV, REM};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(1'b0, at, res, bcnt, stl);
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL fast_result[%0d]: got %h want %h", i, res, exp[i]); end
            checks++; if (at !== 2) begin errors++; $display("FAIL fast_latency[%0d]: got %0d want 2", i, at); end
        end
    endtask

    task automatic test_reset_mid();
        int at, bcnt, dcnt; logic [31:0] res; logic stl;
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h want 0", bus.result); end
        rst = 1'b1;
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (bus.done) dcnt++; end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", dcnt); end
        issue(MUL, 32'd3, 32'd4);
        wait_done(1'b0, at, res, bcnt, stl);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL midrst_mul_result: got %h want 0000000c", res); end
        checks++; if (at !== 35) begin errors++; $display("FAIL midrst_mul_latency: got %0d want 35", at); end
    endtask

    task automatic test_flush();
        int dcnt;
        issue(DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (bus.done) dcnt++; end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", dcnt); end
        checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL flush_result_held: got %h want 0000000c", bus.result); end
        // A flush seen in IDLE must block the accept.
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = MUL;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_blocks: got busy %b want 0", bus.busy); end
        bus.flush = 1'b0; bus.start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int at, bcnt; logic [31:0] res; logic stl;
        issue(MUL, 32'd2, 32'd3);
        wait_done(1'b1, at, res, bcnt, stl);
        checks++; if (res !== 32'd6) begin errors++; $display("FAIL b2b_first_result: got %h want 00000006", res); end
        bus.rs1 = 32'd6;
        bus.rs2 = 32'd7;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_gap: got busy %b done %b want 0 0", bus.busy, bus.done);
        end
        wait_done(1'b0, at, res, bcnt, stl);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL b2b_second_result: got %h want 0000002a", res); end
        checks++; if (at !== 35) begin errors++; $display("FAIL b2b_second_latency: got %0d want 35", at); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast_path();
        test_reset_mid();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
